// File: rtl/nios2_dbg_ocimem_ctrl.sv
// nios2_dbg_ocimem_ctrl
// Debug on-chip memory controller. A single-port debug RAM is shared by the
// JTAG debug slave and the CPU's Avalon-MM slave port. JTAG always wins the
// RAM, and a JTAG command that cannot run right away is parked in a 1-deep
// pending slot.
//
// Ports
//   clk, reset                  single clock, asynchronous active-high reset
//   jdo[37:0]                   JTAG command word, valid with the take_* pulses
//   take_action_ocimem_a        address/control command (jdo[24:17] = address,
//                               jdo[35] = go/clear flags, jdo[34] = clear overrun)
//   take_action_ocimem_b        JTAG RAM write of jdo[34:3] at MonAReg
//   take_no_action_ocimem_a     JTAG RAM read at MonAReg into MonDReg
//   avs_*                       CPU-side Avalon-MM slave (RAM plus control register)
//   MonDReg                     JTAG read data
//   monitor_ready/error/go      debug monitor handshake
//   cmd_overrun                 sticky, set when a JTAG command is dropped
module nios2_dbg_ocimem_ctrl #(
    parameter int         RAM_DEPTH = 256,
    parameter logic [8:0] CTRL_ADDR = 9'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    input  logic [8:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        monitor_go,
    output logic        cmd_overrun
);

    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, JRD, JCAP, CRD} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_WR, CMD_RD, CMD_ADDR} cmd_t;

    logic [31:0]   ram [RAM_DEPTH];
    logic [31:0]   ram_q;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wd;

    state_t        state;
    logic [7:0]    MonAReg;
    logic          pend_valid;
    cmd_t          pend_cmd;
    logic [37:0]   pend_jdo;

    cmd_t          live_cmd;
    cmd_t          exec_cmd;
    logic [37:0]   exec_jdo;
    logic          live_any, live_multi, jtag_req;
    logic          pend_load, pend_drop, pend_done;
    logic          is_ctrl, is_ram, cpu_free, cpu_wr_grant, cpu_rd_issue;
    logic          unused_jdo_bits;

    // Highest-priority live pulse; any additional pulse in the same cycle is lost.
    always_comb begin
        live_cmd = CMD_NONE;
        if (take_action_ocimem_b)
            live_cmd = CMD_WR;
        else if (take_no_action_ocimem_a)
            live_cmd = CMD_RD;
        else if (take_action_ocimem_a)
            live_cmd = CMD_ADDR;
    end

    assign live_any   = (live_cmd != CMD_NONE);
    assign live_multi = (take_action_ocimem_b & (take_no_action_ocimem_a | take_action_ocimem_a))
                      | (take_no_action_ocimem_a & take_action_ocimem_a);
    assign jtag_req   = pend_valid | live_any;

    // In IDLE a parked command runs before any live pulse.
    always_comb begin
        exec_cmd = CMD_NONE;
        exec_jdo = pend_valid ? pend_jdo : jdo;
        if (state == IDLE)
            exec_cmd = pend_valid ? pend_cmd : live_cmd;
    end

    // A live pulse goes into the slot when it cannot run now: either the slot
    // is being drained this IDLE cycle, or the FSM is busy and the slot is free.
    assign pend_done = (state == IDLE) & pend_valid;
    assign pend_load = live_any & (pend_done | ((state != IDLE) & ~pend_valid));
    assign pend_drop = live_any & (state != IDLE) & pend_valid;

    assign is_ctrl      = (avs_address == CTRL_ADDR);
    assign is_ram       = ~is_ctrl & ({23'b0, avs_address} < 32'(RAM_DEPTH));
    assign cpu_free     = (state == IDLE) & ~jtag_req;
    assign cpu_wr_grant = cpu_free & avs_write & is_ram;
    assign cpu_rd_issue = cpu_free & avs_read & ~avs_write & is_ram;

    assign unused_jdo_bits = ^{exec_jdo[37:36], exec_jdo[2:0]};

    // RAM port steering. In JRD the default (MonAReg) address issues the JTAG read.
    always_comb begin
        ram_we   = 1'b0;
        ram_be   = 4'hF;
        ram_addr = AW'(MonAReg);
        ram_wd   = exec_jdo[34:3];
        if (exec_cmd == CMD_WR) begin
            ram_we = 1'b1;
        end else if (cpu_wr_grant) begin
            ram_we   = 1'b1;
            ram_be   = avs_byteenable;
            ram_addr = AW'(avs_address);
            ram_wd   = avs_writedata;
        end else if (cpu_rd_issue) begin
            ram_addr = AW'(avs_address);
        end
    end

    // Debug RAM: no reset so contents survive a debug reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we && ram_be[i])
                ram[ram_addr][i*8 +: 8] <= ram_wd[i*8 +: 8];
        ram_q <= ram[ram_addr];
    end

    // Control-register and unmapped accesses never stall; RAM accesses stall
    // unless they are a granted write or the data phase of a read.
    assign avs_waitrequest = ~reset & (avs_read | avs_write) & is_ram & ~cpu_wr_grant
                           & ~((state == CRD) & avs_read);

    always_comb begin
        avs_readdata = 32'h0;
        if (state == CRD)
            avs_readdata = ram_q;
        else if (avs_read && is_ctrl)
            avs_readdata = {30'b0, monitor_error, monitor_ready};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            MonAReg       <= 8'h0;
            MonDReg       <= 32'h0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            monitor_go    <= 1'b0;
            cmd_overrun   <= 1'b0;
            pend_valid    <= 1'b0;
            pend_cmd      <= CMD_NONE;
            pend_jdo      <= 38'h0;
        end else begin
            monitor_go <= 1'b0;

            // CPU sets come first so a same-cycle JTAG clear overrides them.
            if (avs_write && is_ctrl) begin
                if (avs_writedata[0]) monitor_ready <= 1'b1;
                if (avs_writedata[1]) monitor_error <= 1'b1;
            end

            case (state)
                IDLE: begin
                    case (exec_cmd)
                        CMD_WR: MonAReg <= MonAReg + 8'd1;
                        CMD_RD: state <= JRD;
                        CMD_ADDR: begin
                            MonAReg <= exec_jdo[24:17];
                            if (exec_jdo[35]) begin
                                monitor_ready <= 1'b0;
                                monitor_error <= 1'b0;
                                monitor_go    <= 1'b1;
                            end
                            if (exec_jdo[34]) cmd_overrun <= 1'b0;
                        end
                        default: if (cpu_rd_issue) state <= CRD;
                    endcase
                end
                JRD:  state <= JCAP;
                JCAP: begin
                    MonDReg <= ram_q;
                    MonAReg <= MonAReg + 8'd1;
                    state   <= IDLE;
                end
                CRD:     state <= IDLE;
                default: state <= IDLE;
            endcase

            // A drop in the same cycle as a clear still leaves the flag set.
            if (live_multi || pend_drop) cmd_overrun <= 1'b1;

            if (pend_load) begin
                pend_valid <= 1'b1;
                pend_cmd   <= live_cmd;
                pend_jdo   <= jdo;
            end else if (pend_done) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nios2_dbg_ocimem_ctrl.sv
// Testbench for nios2_dbg_ocimem_ctrl: a cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_nios2_dbg_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [8:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, monitor_go, cmd_overrun;

    nios2_dbg_ocimem_ctrl dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .monitor_go(monitor_go), .cmd_overrun(cmd_overrun)
    );

    always #5 clk = ~clk;

    // jt = {ocimem_b, no_action_ocimem_a, action_ocimem_a}; e_fl = {ready, error, go, overrun}
    typedef struct {
        logic [2:0]  jt;
        logic [37:0] j;
        logic        rd, wr;
        logic [8:0]  ad;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        e_w;
        logic [31:0] e_rd;
        logic [31:0] e_md;
        logic [7:0]  e_ma;
        logic [3:0]  e_fl;
    } vec_t;

    localparam logic [2:0] JN = 3'b000, JA = 3'b001, JR = 3'b010, JB = 3'b100;
    localparam logic [31:0] DB = 32'hDEADBEEF, CF = 32'hCAFEF00D, BY = 32'hAA22CC44;

    int n_chk = 0;
    int n_pass = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] jt, input logic [37:0] j,
                                input logic rd, input logic wr, input logic [8:0] ad,
                                input logic [31:0] wd, input logic [3:0] be,
                                input logic e_w, input logic [31:0] e_rd,
                                input logic [31:0] e_md, input logic [7:0] e_ma,
                                input logic [3:0] e_fl);
        vec_t v;
        v.jt = jt; v.j = j; v.rd = rd; v.wr = wr; v.ad = ad; v.wd = wd; v.be = be;
        v.e_w = e_w; v.e_rd = e_rd; v.e_md = e_md; v.e_ma = e_ma; v.e_fl = e_fl;
        return v;
    endfunction

    function automatic logic [37:0] ja(input logic [7:0] a, input logic go, input logic clr);
        return {2'b00, go, clr, 9'h0, a, 17'h0};
    endfunction

    function automatic logic [37:0] jw(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic [2:0] jt, input logic [37:0] j, input logic rd,
                         input logic wr, input logic [8:0] ad, input logic [31:0] wd,
                         input logic [3:0] be);
        take_action_ocimem_b    = jt[2];
        take_no_action_ocimem_a = jt[1];
        take_action_ocimem_a    = jt[0];
        jdo = j; avs_read = rd; avs_write = wr; avs_address = ad;
        avs_writedata = wd; avs_byteenable = be;
    endtask

    task automatic idle_in();
        drive(JN, 38'h0, 1'b0, 1'b0, 9'h0, 32'h0, 4'hF);
    endtask

    // Called at posedge+1: drive, check the combinational Avalon outputs,
    // clock once, then check the registered state.
    task automatic run_vec(input vec_t v, input int i);
        drive(v.jt, v.j, v.rd, v.wr, v.ad, v.wd, v.be);
        #1;
        chk($sformatf("r%0d_waitrequest", i), {31'b0, avs_waitrequest}, {31'b0, v.e_w});
        chk($sformatf("r%0d_readdata", i), avs_readdata, v.e_rd);
        @(posedge clk); #1;
        chk($sformatf("r%0d_MonDReg", i), MonDReg, v.e_md);
        chk($sformatf("r%0d_MonAReg", i), {24'b0, dut.MonAReg}, {24'b0, v.e_ma});
        chk($sformatf("r%0d_flags", i),
            {28'b0, monitor_ready, monitor_error, monitor_go, cmd_overrun}, {28'b0, v.e_fl});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_MonDReg"}, MonDReg, 32'h0);
        chk({tag, "_flags"}, {28'b0, monitor_ready, monitor_error, monitor_go, cmd_overrun}, 32'h0);
        chk({tag, "_waitrequest"}, {31'b0, avs_waitrequest}, 32'h0);
        chk({tag, "_readdata"}, avs_readdata, 32'h0);
        chk({tag, "_MonAReg"}, {24'b0, dut.MonAReg}, 32'h0);
    endtask

    initial begin
        // Address/read path and address register
        tbl.push_back(mk(JA, ja(8'h10,0,0), 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h0,8'h10,4'b0000));
        tbl.push_back(mk(JB, jw(DB),         0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h0,8'h11,4'b0000));
        tbl.push_back(mk(JA, ja(8'h10,0,0), 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h0,8'h10,4'b0000));
        tbl.push_back(mk(JR, 38'h0,          0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h0,8'h10,4'b0000));
        tbl.push_back(mk(JN, 38'h0,          0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h0,8'h10,4'b0000));
        tbl.push_back(mk(JN, 38'h0,          0,0,9'h0,32'h0,4'hF, 0,32'h0,DB,   8'h11,4'b0000));
        // Address wrap 0xFF -> 0x00
        tbl.push_back(mk(JA, ja(8'hFF,0,0), 0,0,9'h0,32'h0,4'hF, 0,32'h0,DB,8'hFF,4'b0000));
        tbl.push_back(mk(JB, jw(32'h11111111),0,0,9'h0,32'h0,4'hF,0,32'h0,DB,8'h00,4'b0000));
        tbl.push_back(mk(JB, jw(32'h22222222),0,0,9'h0,32'h0,4'hF,0,32'h0,DB,8'h01,4'b0000));
        // CPU reads of RAM[255], RAM[0]
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h0FF,32'h0,4'hF, 1,32'h0,        DB,8'h01,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h0FF,32'h0,4'hF, 0,32'h11111111, DB,8'h01,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h000,32'h0,4'hF, 1,32'h0,        DB,8'h01,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h000,32'h0,4'hF, 0,32'h22222222, DB,8'h01,4'b0000));
        // CPU writes with byte enables
        tbl.push_back(mk(JN, 38'h0, 0,1,9'h005,32'hAABBCCDD,4'hF,   0,32'h0,DB,8'h01,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 0,1,9'h005,32'h11223344,4'b0101,0,32'h0,DB,8'h01,4'b0000));
        // Contention: JTAG write beats CPU read, CPU retries
        tbl.push_back(mk(JB, jw(CF), 1,0,9'h005,32'h0,4'hF, 1,32'h0,DB,8'h02,4'b0000));
        tbl.push_back(mk(JN, 38'h0,  1,0,9'h005,32'h0,4'hF, 1,32'h0,DB,8'h02,4'b0000));
        tbl.push_back(mk(JN, 38'h0,  1,0,9'h005,32'h0,4'hF, 0,BY,   DB,8'h02,4'b0000));
        // JTAG read of RAM[1], CPU stalled during JRD/JCAP
        tbl.push_back(mk(JA, ja(8'h01,0,0), 0,0,9'h000,32'h0,4'hF, 0,32'h0,DB,8'h01,4'b0000));
        tbl.push_back(mk(JR, 38'h0, 0,0,9'h000,32'h0,4'hF, 0,32'h0,DB,8'h01,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h005,32'h0,4'hF, 1,32'h0,DB,8'h01,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h005,32'h0,4'hF, 1,32'h0,CF,8'h02,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h005,32'h0,4'hF, 1,32'h0,CF,8'h02,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h005,32'h0,4'hF, 0,BY,   CF,8'h02,4'b0000));
        // Monitor handshake and clear-wins
        tbl.push_back(mk(JN, 38'h0, 0,1,9'h100,32'h3,4'hF, 0,32'h0,CF,8'h02,4'b1100));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h100,32'h0,4'hF, 0,32'h3,CF,8'h02,4'b1100));
        tbl.push_back(mk(JA, ja(8'h20,1,0), 0,0,9'h0,32'h0,4'hF, 0,32'h0,CF,8'h20,4'b0010));
        tbl.push_back(mk(JN, 38'h0, 0,0,9'h000,32'h0,4'hF, 0,32'h0,CF,8'h20,4'b0000));
        tbl.push_back(mk(JA, ja(8'h20,1,0), 0,1,9'h100,32'h1,4'hF, 0,32'h0,CF,8'h20,4'b0010));
        tbl.push_back(mk(JN, 38'h0, 0,1,9'h100,32'h2,4'hF, 0,32'h0,CF,8'h20,4'b0100));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h100,32'h0,4'hF, 0,32'h2,CF,8'h20,4'b0100));
        tbl.push_back(mk(JA, ja(8'h20,1,0), 0,0,9'h0,32'h0,4'hF, 0,32'h0,CF,8'h20,4'b0010));
        // Unmapped address: zero-wait, write ignored, read 0
        tbl.push_back(mk(JN, 38'h0, 0,1,9'h1FF,32'hFFFFFFFF,4'hF, 0,32'h0,CF,8'h20,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h1FF,32'h0,4'hF, 0,32'h0,CF,8'h20,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h100,32'h0,4'hF, 0,32'h0,CF,8'h20,4'b0000));
        // Pending slot and overrun
        tbl.push_back(mk(JB, jw(32'h20), 0,0,9'h0,32'h0,4'hF, 0,32'h0,CF,8'h21,4'b0000));
        tbl.push_back(mk(JB, jw(32'h21), 0,0,9'h0,32'h0,4'hF, 0,32'h0,CF,8'h22,4'b0000));
        tbl.push_back(mk(JA, ja(8'h20,0,0), 0,0,9'h0,32'h0,4'hF, 0,32'h0,CF,8'h20,4'b0000));
        tbl.push_back(mk(JR, 38'h0, 0,0,9'h0,32'h0,4'hF, 0,32'h0,CF,   8'h20,4'b0000));
        tbl.push_back(mk(JR, 38'h0, 0,0,9'h0,32'h0,4'hF, 0,32'h0,CF,   8'h20,4'b0000));
        tbl.push_back(mk(JR, 38'h0, 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h20,8'h21,4'b0001));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h005,32'h0,4'hF, 1,32'h0,32'h20,8'h21,4'b0001));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h005,32'h0,4'hF, 1,32'h0,32'h20,8'h21,4'b0001));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h005,32'h0,4'hF, 1,32'h0,32'h21,8'h22,4'b0001));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h005,32'h0,4'hF, 1,32'h0,32'h21,8'h22,4'b0001));
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h005,32'h0,4'hF, 0,BY,   32'h21,8'h22,4'b0001));
        tbl.push_back(mk(JA, ja(8'h22,0,1), 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h21,8'h22,4'b0000));
        // Simultaneous b + a: write wins, address command dropped
        tbl.push_back(mk(JB|JA, jw(32'h12345678), 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h21,8'h23,4'b0001));
        tbl.push_back(mk(JA, ja(8'h22,0,1), 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h21,8'h22,4'b0000));
        tbl.push_back(mk(JR, 38'h0, 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h21,      8'h22,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h21,      8'h22,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h12345678,8'h23,4'b0000));
        // JTAG write pended during CRD
        tbl.push_back(mk(JN, 38'h0, 1,0,9'h005,32'h0,4'hF, 1,32'h0,32'h12345678,8'h23,4'b0000));
        tbl.push_back(mk(JB, jw(32'hBEEF), 1,0,9'h005,32'h0,4'hF, 0,BY,32'h12345678,8'h23,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h12345678,8'h24,4'b0000));
        tbl.push_back(mk(JA, ja(8'h23,0,0), 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h12345678,8'h23,4'b0000));
        tbl.push_back(mk(JR, 38'h0, 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h12345678,8'h23,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'h12345678,8'h23,4'b0000));
        tbl.push_back(mk(JN, 38'h0, 0,0,9'h0,32'h0,4'hF, 0,32'h0,32'hBEEF,    8'h24,4'b0000));

        // Reset state, with a CPU RAM read held during reset
        reset = 1'b1;
        idle_in();
        avs_read = 1'b1; avs_address = 9'h005;
        #2;
        chk_reset_vals("reset");
        avs_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Reset in JRD: flags, overrun and MonDReg all nonzero beforehand
        drive(JB|JA, jw(32'h0), 1'b0, 1'b1, 9'h100, 32'h3, 4'hF);
        @(posedge clk); #1;
        chk("pre_flags", {28'b0, monitor_ready, monitor_error, monitor_go, cmd_overrun}, 32'hD);
        drive(JA, ja(8'h10,0,0), 1'b0, 1'b0, 9'h0, 32'h0, 4'hF);
        @(posedge clk); #1;
        drive(JR, 38'h0, 1'b0, 1'b0, 9'h0, 32'h0, 4'hF);
        @(posedge clk); #1;
        idle_in();
        chk("jrd_MonDReg", MonDReg, 32'hBEEF);
        #2 reset = 1'b1;
        avs_read = 1'b1; avs_address = 9'h005;
        #1;
        chk_reset_vals("mid_jrd");
        avs_read = 1'b0;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst%0d_MonDReg", k), MonDReg, 32'h0);
        end

        // RAM contents survive reset: RAM[0x10] still holds DEADBEEF
        drive(JA, ja(8'h10,0,0), 1'b0, 1'b0, 9'h0, 32'h0, 4'hF);
        @(posedge clk); #1;
        drive(JR, 38'h0, 1'b0, 1'b0, 9'h0, 32'h0, 4'hF);
        @(posedge clk); #1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("ram_keep_MonDReg", MonDReg, DB);
        chk("ram_keep_MonAReg", {24'b0, dut.MonAReg}, 32'h11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
